// File: rtl/flatten_pkg.sv
// Shared types and helpers for the flatten/reorder stage between the last
// conv/pool layer and the first fully connected layer.
package flatten_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILL    = 2'd1,
        REORDER = 2'd2,
        READY   = 2'd3
    } state_t;

    localparam logic MODE_TRANSPOSE = 1'b0;
    localparam logic MODE_PASS      = 1'b1;

    function automatic int clog2(input int v);
        int r;
        for (r = 0; (1 << r) < v; r++) begin
        end
        return r;
    endfunction

endpackage

// File: rtl/flatten_bank_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port
// whose output holds while re is low and clears on reset.
module flatten_bank_ram
    import flatten_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    localparam int AW = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/flatten_reorder.sv
// Buffers one channel-fastest frame in bank RAM A, then rewrites it one element
// per cycle into bank RAM B in feature-major (or unchanged) order for the FC layer.
module flatten_reorder
    import flatten_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int CHANNELS   = 64,
    parameter int SPATIAL    = 16,
    parameter int IN_PAR     = 8,
    parameter int OUT_PAR    = 32,
    localparam int N         = CHANNELS * SPATIAL,
    localparam int RD_AW     = (clog2(N / OUT_PAR) > 0) ? clog2(N / OUT_PAR) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          mode,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_WIDTH*IN_PAR-1:0]  in_data,
    input  logic                          rd_en,
    input  logic [RD_AW-1:0]              rd_addr,
    output logic [DATA_WIDTH*OUT_PAR-1:0] rd_data,
    output logic                          busy,
    output logic                          frame_ready,
    output logic                          flatten_done
);

    localparam int CW     = clog2(N) + 1;
    localparam int ADEPTH = N / IN_PAR;
    localparam int BDEPTH = N / OUT_PAR;
    localparam int AAW    = (clog2(ADEPTH) > 0) ? clog2(ADEPTH) : 1;
    localparam int LA     = (clog2(IN_PAR) > 0) ? clog2(IN_PAR) : 1;
    localparam int LB     = (clog2(OUT_PAR) > 0) ? clog2(OUT_PAR) : 1;

    localparam logic [CW-1:0] N_C       = CW'(N);
    localparam logic [CW-1:0] LAST_BEAT = CW'(ADEPTH - 1);
    localparam logic [CW-1:0] LAST_J    = CW'(N - 1);
    localparam logic [CW-1:0] LAST_S    = CW'(SPATIAL - 1);

    state_t          state, state_nx;
    logic            mode_q;
    logic [CW-1:0]   beat_cnt;
    logic [CW-1:0]   rd_cnt;
    logic [CW-1:0]   rd_idx;
    logic [CW-1:0]   s_cnt, c_cnt;
    logic            vld_p1;
    logic [CW-1:0]   j_p1;
    logic [LA-1:0]   lane_p1;
    logic            done_q;

    logic            arm, accept, rd_issue, last_wr;
    logic [AAW-1:0]  a_raddr;
    logic [RD_AW-1:0] b_waddr;
    logic [LB-1:0]   b_lane;
    logic [DATA_WIDTH-1:0] a_rdata [IN_PAR];
    logic [DATA_WIDTH-1:0] a_elem;

    assign arm      = start && (state == IDLE || state == READY);
    assign in_ready = (state == FILL);
    assign accept   = in_valid && in_ready;
    assign rd_issue = (state == REORDER) && (rd_cnt < N_C);
    assign last_wr  = vld_p1 && (j_p1 == LAST_J);

    assign busy         = (state == FILL) || (state == REORDER);
    assign frame_ready  = (state == READY);
    assign flatten_done = done_q;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = FILL;
            FILL:    if (accept && beat_cnt == LAST_BEAT) state_nx = REORDER;
            REORDER: if (last_wr) state_nx = READY;
            READY:   if (start) state_nx = FILL;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            mode_q   <= MODE_TRANSPOSE;
            beat_cnt <= '0;
            rd_cnt   <= '0;
            rd_idx   <= '0;
            s_cnt    <= '0;
            c_cnt    <= '0;
            vld_p1   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state  <= state_nx;
            vld_p1 <= rd_issue;
            done_q <= (state == REORDER) && last_wr;
            if (arm) begin
                mode_q   <= mode;
                beat_cnt <= '0;
                rd_cnt   <= '0;
                rd_idx   <= '0;
                s_cnt    <= '0;
                c_cnt    <= '0;
            end
            if (accept) begin
                beat_cnt <= beat_cnt + CW'(1);
            end
            if (rd_issue) begin
                rd_cnt <= rd_cnt + CW'(1);
                if (mode_q == MODE_PASS) begin
                    rd_idx <= rd_idx + CW'(1);
                end else if (s_cnt == LAST_S) begin
                    // finished one channel column: restart at the next channel
                    s_cnt  <= '0;
                    c_cnt  <= c_cnt + CW'(1);
                    rd_idx <= c_cnt + CW'(1);
                end else begin
                    s_cnt  <= s_cnt + CW'(1);
                    rd_idx <= rd_idx + CW'(CHANNELS);
                end
            end
        end
    end

    // ---- p0 -> p1: buffer A read in flight, remember target position and lane
    always_ff @(posedge clk) begin
        j_p1    <= rd_cnt;
        lane_p1 <= LA'(rd_idx % CW'(IN_PAR));
    end

    assign a_raddr = AAW'(rd_idx / CW'(IN_PAR));
    assign a_elem  = a_rdata[lane_p1];
    assign b_waddr = RD_AW'(j_p1 / CW'(OUT_PAR));
    assign b_lane  = LB'(j_p1 % CW'(OUT_PAR));

    for (genvar k = 0; k < IN_PAR; k++) begin : g_bank_a
        flatten_bank_ram #(
            .WIDTH(DATA_WIDTH),
            .DEPTH(ADEPTH)
        ) u_bank_a (
            .clk   (clk),
            .rst_n (rst_n),
            .we    (accept),
            .waddr (beat_cnt[AAW-1:0]),
            .wdata (in_data[k*DATA_WIDTH +: DATA_WIDTH]),
            .re    (rd_issue),
            .raddr (a_raddr),
            .rdata (a_rdata[k])
        );
    end

    for (genvar k = 0; k < OUT_PAR; k++) begin : g_bank_b
        flatten_bank_ram #(
            .WIDTH(DATA_WIDTH),
            .DEPTH(BDEPTH)
        ) u_bank_b (
            .clk   (clk),
            .rst_n (rst_n),
            .we    (vld_p1 && (b_lane == LB'(k))),
            .waddr (b_waddr),
            .wdata (a_elem),
            .re    (rd_en),
            .raddr (rd_addr),
            .rdata (rd_data[k*DATA_WIDTH +: DATA_WIDTH])
        );
    end

endmodule

// File: tb/tb_flatten_reorder.sv
// Scoreboarded bench for flatten_reorder: default geometry (all modes, throttled
// input, mid-reorder reset) plus a small 8x4 geometry instance.
module tb_flatten_reorder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         start, mode, in_valid, in_ready, rd_en;
    logic [127:0] in_data;
    logic [4:0]   rd_addr;
    logic [511:0] rd_data;
    logic         busy, frame_ready, flatten_done;

    logic         s_start, s_mode, s_in_valid, s_in_ready, s_rd_en;
    logic [63:0]  s_in_data;
    logic [1:0]   s_rd_addr;
    logic [127:0] s_rd_data;
    logic         s_busy, s_frame_ready, s_flatten_done;

    int n_vec = 0;
    int n_err = 0;

    flatten_reorder u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .frame_ready(frame_ready), .flatten_done(flatten_done)
    );

    flatten_reorder #(
        .DATA_WIDTH(16), .CHANNELS(8), .SPATIAL(4), .IN_PAR(4), .OUT_PAR(8)
    ) u1 (
        .clk(clk), .rst_n(rst_n), .start(s_start), .mode(s_mode),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
        .rd_en(s_rd_en), .rd_addr(s_rd_addr), .rd_data(s_rd_data),
        .busy(s_busy), .frame_ready(s_frame_ready), .flatten_done(s_flatten_done)
    );

    typedef struct { logic [511:0] exp; int addr; } sb0_t;
    typedef struct { logic [127:0] exp; int addr; } sb1_t;
    sb0_t q0[$];
    sb1_t q1[$];
    sb0_t e0;
    sb1_t e1;
    logic pend0 = 1'b0;
    logic pend1 = 1'b0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end
    endtask

    // Feature-major model: output j -> channel j/SPATIAL, position j%SPATIAL
    function automatic logic [511:0] exp_word(input int a, input bit m, input int off);
        logic [511:0] w;
        int j, v;
        w = '0;
        for (int k = 0; k < 32; k++) begin
            j = a * 32 + k;
            v = m ? j : (j % 16) * 64 + j / 16;
            w[k*16 +: 16] = 16'(v + off);
        end
        return w;
    endfunction

    function automatic logic [127:0] exp_small(input int a);
        logic [127:0] w;
        int j;
        w = '0;
        for (int k = 0; k < 8; k++) begin
            j = a * 8 + k;
            w[k*16 +: 16] = 16'((j % 4) * 8 + j / 4);
        end
        return w;
    endfunction

    function automatic logic [127:0] beat0(input int b, input int off);
        logic [127:0] d;
        for (int k = 0; k < 8; k++) d[k*16 +: 16] = 16'(b * 8 + k + off);
        return d;
    endfunction

    always @(posedge clk) begin
        pend0 <= rd_en;
        pend1 <= s_rd_en;
    end

    always @(negedge clk) begin
        if (pend0) begin
            n_vec++;
            if (q0.size() == 0) begin
                n_err++;
                $display("FAIL sb0_underflow got=%h want=none", rd_data);
            end else begin
                e0 = q0.pop_front();
                if (rd_data !== e0.exp) begin
                    n_err++;
                    $display("FAIL rd_word addr=%0d got=%h want=%h", e0.addr, rd_data, e0.exp);
                end
            end
        end
        if (pend1) begin
            n_vec++;
            if (q1.size() == 0) begin
                n_err++;
                $display("FAIL sb1_underflow got=%h want=none", s_rd_data);
            end else begin
                e1 = q1.pop_front();
                if (s_rd_data !== e1.exp) begin
                    n_err++;
                    $display("FAIL small_rd_word addr=%0d got=%h want=%h", e1.addr, s_rd_data, e1.exp);
                end
            end
        end
    end

    task automatic do_start(input bit m);
        @(negedge clk);
        start = 1'b1; mode = m; in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0; mode = 1'b0;
        chk("start_frame_ready_low", 64'(frame_ready), 64'd0);
        chk("start_in_ready_high", 64'(in_ready), 64'd1);
    endtask

    task automatic feed(input int off, input bit rnd);
        int b = 0;
        int guard = 0;
        bit acc;
        while (b < 128 && guard < 3000) begin
            @(negedge clk);
            guard++;
            in_valid = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
            in_data  = beat0(b, off);
            start    = rnd && (b == 40);
            mode     = start;
            acc      = in_valid && in_ready;
            @(posedge clk);
            if (acc) b++;
        end
        chk("feed_beats", 64'(b), 64'd128);
        #1;
        in_valid = rnd;
        in_data  = '1;
        start    = 1'b0;
        mode     = 1'b0;
    endtask

    task automatic wait_done(input int exp, input bit poke);
        int cnt = 0;
        bit got = 0;
        while (!got && cnt < 3000) begin
            @(posedge clk);
            cnt++;
            #1;
            if (cnt == 1) chk("in_ready_in_reorder", 64'(in_ready), 64'd0);
            if (poke && cnt == 100) begin start = 1'b1; mode = 1'b1; end
            if (poke && cnt == 101) begin
                start = 1'b0; mode = 1'b0;
                chk("busy_after_start_in_reorder", 64'(busy), 64'd1);
                chk("frame_ready_in_reorder", 64'(frame_ready), 64'd0);
            end
            if (flatten_done) got = 1;
        end
        chk("done_latency", 64'(cnt), 64'(exp));
        chk("frame_ready_at_done", 64'(frame_ready), 64'd1);
        chk("busy_at_done", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        chk("done_pulse_width", 64'(flatten_done), 64'd0);
    endtask

    task automatic read_one(input int a, input bit m, input int off, output logic [511:0] w);
        @(negedge clk);
        rd_en = 1'b1; rd_addr = 5'(a);
        q0.push_back('{exp_word(a, m, off), a});
        @(negedge clk);
        rd_en = 1'b0;
        w = rd_data;
    endtask

    task automatic read_all(input bit m, input int off);
        for (int a = 0; a < 32; a++) begin
            @(negedge clk);
            rd_en = 1'b1; rd_addr = 5'(a);
            q0.push_back('{exp_word(a, m, off), a});
        end
        @(negedge clk);
        rd_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("sb0_drained", 64'(q0.size()), 64'd0);
    endtask

    initial begin
        logic [511:0] w;
        int n_done;
        int cnt;
        bit got;
        int hand [8] = '{0, 8, 16, 24, 1, 9, 17, 25};

        rst_n = 1'b0; start = 1'b0; mode = 1'b0; in_valid = 1'b0; in_data = '0;
        rd_en = 1'b0; rd_addr = '0;
        s_start = 1'b0; s_mode = 1'b0; s_in_valid = 1'b0; s_in_data = '0;
        s_rd_en = 1'b0; s_rd_addr = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_frame_ready", 64'(frame_ready), 64'd0);
        chk("rst_flatten_done", 64'(flatten_done), 64'd0);
        chk("rst_rd_data_any", 64'(|rd_data), 64'd0);
        chk("rst_small_busy", 64'(s_busy), 64'd0);
        rst_n = 1'b1;

        // garbage beats offered while idle must not be taken
        in_valid = 1'b1; in_data = '1;
        repeat (3) @(negedge clk);
        chk("idle_in_ready", 64'(in_ready), 64'd0);

        // transpose, continuous input
        do_start(1'b0);
        feed(0, 1'b0);
        wait_done(1025, 1'b0);
        read_all(1'b0, 0);
        read_one(0, 1'b0, 0, w);
        chk("addr0_lane1", 64'(w[1*16 +: 16]), 64'd64);
        chk("addr0_lane15", 64'(w[15*16 +: 16]), 64'd960);
        chk("addr0_lane16", 64'(w[16*16 +: 16]), 64'd1);
        rd_addr = 5'd7;
        repeat (3) @(negedge clk);
        chk("rd_hold_lane16", 64'(rd_data[16*16 +: 16]), 64'd1);
        chk("rd_hold_lane1", 64'(rd_data[1*16 +: 16]), 64'd64);
        read_one(31, 1'b0, 0, w);
        chk("addr31_lane31", 64'(w[31*16 +: 16]), 64'd1023);

        // pass-through, restarted from READY
        in_valid = 1'b1; in_data = '1;
        repeat (3) @(negedge clk);
        do_start(1'b1);
        feed(0, 1'b0);
        wait_done(1025, 1'b0);
        read_all(1'b1, 0);

        // throttled input, stray valids and ignored starts
        in_valid = 1'b1; in_data = '1;
        repeat (4) @(negedge clk);
        do_start(1'b0);
        feed(0, 1'b1);
        wait_done(1025, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        read_all(1'b0, 0);

        // reset during reorder, then a fresh frame
        do_start(1'b0);
        feed(0, 1'b0);
        repeat (300) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_in_ready", 64'(in_ready), 64'd0);
        chk("abort_frame_ready", 64'(frame_ready), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        repeat (1200) begin
            @(negedge clk);
            if (flatten_done) n_done++;
        end
        chk("abort_no_done", 64'(n_done), 64'd0);
        chk("abort_idle_busy", 64'(busy), 64'd0);
        do_start(1'b0);
        feed(5000, 1'b0);
        wait_done(1025, 1'b0);
        read_all(1'b0, 5000);
        read_one(0, 1'b0, 5000, w);
        chk("refill_addr0_lane1", 64'(w[1*16 +: 16]), 64'd5064);

        // small geometry 8 channels x 4 positions
        @(negedge clk);
        s_start = 1'b1; s_mode = 1'b0;
        @(negedge clk);
        s_start = 1'b0;
        chk("small_in_ready", 64'(s_in_ready), 64'd1);
        for (int b = 0; b < 8; b++) begin
            @(negedge clk);
            s_in_valid = 1'b1;
            for (int k = 0; k < 4; k++) s_in_data[k*16 +: 16] = 16'(b * 4 + k);
            @(posedge clk);
        end
        #1;
        s_in_valid = 1'b0;
        cnt = 0; got = 0;
        while (!got && cnt < 200) begin
            @(posedge clk);
            cnt++;
            #1;
            if (s_flatten_done) got = 1;
        end
        chk("small_done_latency", 64'(cnt), 64'd33);
        chk("small_frame_ready", 64'(s_frame_ready), 64'd1);
        for (int a = 0; a < 4; a++) begin
            @(negedge clk);
            s_rd_en = 1'b1; s_rd_addr = 2'(a);
            q1.push_back('{exp_small(a), a});
        end
        @(negedge clk);
        s_rd_en = 1'b1; s_rd_addr = 2'd0;
        q1.push_back('{exp_small(0), 0});
        @(negedge clk);
        s_rd_en = 1'b0;
        for (int k = 0; k < 8; k++)
            chk("small_addr0_lane", 64'(s_rd_data[k*16 +: 16]), 64'(hand[k]));
        repeat (3) @(negedge clk);
        chk("sb1_drained", 64'(q1.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
